// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU definitions: function codes, condition-code bit layout and reset value.
package alu_defs;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_exec_unit_alu64.sv
// Stateless Y86-64 OPq datapath: valE = b OP a, plus the flags that result would set.
module alu64_comb
  import alu_defs::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ifun,
  output logic [WIDTH-1:0] val_e,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    val_e   = '0;
    of      = 1'b0;
    illegal = 1'b0;
    unique case (ifun)
      ALU_ADD: begin
        val_e = b + a;
        of    = (a[MSB] == b[MSB]) && (val_e[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        val_e = b - a;
        of    = (a[MSB] != b[MSB]) && (val_e[MSB] != b[MSB]);
      end
      ALU_AND: val_e = b & a;
      ALU_XOR: val_e = b ^ a;
      default: illegal = 1'b1;
    endcase
  end

  assign zf = (val_e == '0);
  assign sf = val_e[MSB];

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage execute unit: operand register, registered ALU result, and the ZF/SF/OF register.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       cc
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_ifun;
  logic             s1_set_cc;

  logic             s2_ready;
  logic             s1_advance;
  logic             in_fire;

  logic [WIDTH-1:0] val_e;
  logic             zf;
  logic             sf;
  logic             of;
  logic             illegal;
  logic [2:0]       cc_next;

  // Stage 2 can take a beat when empty or when its current beat leaves this cycle.
  assign s2_ready   = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_ready;
  assign in_ready   = !s1_valid || s2_ready;
  assign in_fire    = in_valid && in_ready;

  alu64_comb #(.WIDTH(WIDTH)) u_alu (
    .a       (s1_a),
    .b       (s1_b),
    .ifun    (s1_ifun),
    .val_e   (val_e),
    .zf      (zf),
    .sf      (sf),
    .of      (of),
    .illegal (illegal)
  );

  always_comb begin
    cc_next        = '0;
    cc_next[CC_ZF] = zf;
    cc_next[CC_SF] = sf;
    cc_next[CC_OF] = of;
  end

  // NOTE: stage-1 payload is only consumed when s1_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_a      <= a;
      s1_b      <= b;
      s1_ifun   <= ifun;
      s1_set_cc <= set_cc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      cc        <= CC_RESET;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_ready) out_valid <= s1_valid;
      if (s1_advance) begin
        result <= val_e;
        err    <= illegal;
        // Illegal function codes never disturb the architectural flags.
        if (s1_set_cc && !illegal) cc <= cc_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner beats plus random traffic against a queue model.
module tb_alu_exec_unit;
  import alu_defs::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ifun;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         err;
  logic [2:0]   cc;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .a         (a),
    .b         (b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .cc        (cc)
  );

  typedef struct packed {
    logic [63:0] res;
    logic        err;
    logic [2:0]  cc;
  } exp_t;

  exp_t        exp_q[$];
  logic [2:0]  model_cc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;

  logic        hold_pending = 1'b0;
  logic [63:0] hold_res;
  logic        hold_err;
  logic        last_out_fire;
  logic        last_in_ready;
  logic [63:0] last_res;
  logic        last_err;
  logic [2:0]  last_cc;

  localparam logic signed [64:0] SMAX = $signed({1'b0, 64'h7FFF_FFFF_FFFF_FFFF});
  localparam logic signed [64:0] SMIN = $signed({1'b1, 64'h8000_0000_0000_0000});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference: Y86 semantics with mathematically exact signed arithmetic, flags applied in accept order.
  task automatic ref_push(input logic [63:0] ia, input logic [63:0] ib, input logic [3:0] f,
                          input logic sc);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic        e;
    logic        o;
    e = 1'b0;
    o = 1'b0;
    r = '0;
    case (f)
      4'd0: begin
        wide = $signed({ib[63], ib}) + $signed({ia[63], ia});
        r = wide[63:0];
        o = (wide > SMAX) || (wide < SMIN);
      end
      4'd1: begin
        wide = $signed({ib[63], ib}) - $signed({ia[63], ia});
        r = wide[63:0];
        o = (wide > SMAX) || (wide < SMIN);
      end
      4'd2: r = ib & ia;
      4'd3: r = ib ^ ia;
      default: e = 1'b1;
    endcase
    if (sc && !e) model_cc = {(r == 64'd0), r[63], o};
    exp_q.push_back('{res: r, err: e, cc: model_cc});
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, then wait for the active edge.
  task automatic cycle(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                       input logic [3:0] f, input logic sc, input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    ifun      = f;
    set_cc    = sc;
    out_ready = ordy;
    #1;
    acc           = iv && in_ready;
    last_in_ready = in_ready;
    last_out_fire = out_valid && out_ready;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", result, hold_res);
      check("hold_err", err, hold_err);
    end
    if (out_valid && out_ready) begin
      n_out++;
      last_res = result;
      last_err = err;
      last_cc  = cc;
      if (exp_q.size() == 0) begin
        check("stale_out_valid", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("err", err, e.err);
        check("cc", cc, e.cc);
      end
    end
    hold_pending = out_valid && !out_ready;
    hold_res     = result;
    hold_err     = err;
    if (acc) ref_push(ia, ib, f, sc);
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, '0, '0, 4'd0, 1'b0, ordy, acc);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) idle(1'b1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Single beat into an empty pipe with explicit expected values and latency.
  task automatic run_one(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [3:0] f, input logic sc, input logic [63:0] want_res,
                         input logic want_err, input logic [2:0] want_cc);
    logic acc;
    logic got;
    int   lat;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, ia, ib, f, sc, 1'b1, acc);
    check({tag, "_accept"}, acc, 1'b1);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      idle(1'b1);
      if (last_out_fire) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_result"}, last_res, want_res);
    check({tag, "_err"}, last_err, want_err);
    check({tag, "_cc"}, last_cc, want_cc);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 64'd5;
    b         = 64'd9;
    ifun      = 4'd0;
    set_cc    = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    model_cc     = CC_RESET;
    hold_pending = 1'b0;
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc;
    logic        saw_full;
    int          idx;
    int          n0;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [3:0]  rf;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ifun      = '0;
    set_cc    = 1'b0;
    out_ready = 1'b0;
    model_cc  = CC_RESET;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 64'd0);
    check("rst_err", err, 1'b0);
    check("rst_cc", cc, 3'b100);
    check("rst_in_ready", in_ready, 1'b1);

    // Directed corner beats.
    run_one("xor", 64'hFFFF_FFFF, 64'hFFFF_FF9B, 4'd3, 1'b1, 64'h64, 1'b0, 3'b000);
    run_one("sub_eq", 64'h1234, 64'h1234, 4'd1, 1'b1, 64'd0, 1'b0, 3'b100);
    run_one("sub_nocc", 64'd1, 64'd0, 4'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b100);
    run_one("and", 64'hF0F0, 64'hFF00, 4'd2, 1'b1, 64'hF000, 1'b0, 3'b000);
    run_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b011);
    run_one("illegal", 64'h55, 64'hAA, 4'd7, 1'b1, 64'd0, 1'b1, 3'b011);
    run_one("sub_ovf", 64'd1, 64'h8000_0000_0000_0000, 4'd1, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001);

    // Back-pressure: 16 beats with a 5-cycle output stall mid-stream.
    n0       = n_out;
    idx      = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
      cycle(1'b1, 64'hFFFF_FFFF - 64'(idx), 64'(idx * 3 + 1), 4'(idx % 4), 1'b1,
            !(cyc >= 4 && cyc < 9), acc);
      if (!last_in_ready) saw_full = 1'b1;
      if (acc) idx++;
    end
    check("bp_all_sent", idx, 16);
    check("bp_in_ready_dropped", saw_full, 1'b1);
    drain("bp");
    check("bp_count", n_out - n0, 16);

    // Reset with both stages full.
    cycle(1'b1, 64'd1, 64'd3, 4'd1, 1'b1, 1'b0, acc);
    cycle(1'b1, 64'd2, 64'd7, 4'd1, 1'b1, 1'b0, acc);
    idle(1'b0);
    check("full_in_ready", last_in_ready, 1'b0);
    check("full_cc_before_rst", cc, 3'b000);
    apply_reset();
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_cc", cc, 3'b100);
    check("mid_rst_in_ready", in_ready, 1'b1);
    n0 = n_out;
    repeat (6) idle(1'b1);
    check("mid_rst_no_stale", n_out - n0, 0);

    // Random traffic with random back-pressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      ra = rnd_op();
      rb = ($urandom_range(0, 7) == 0) ? ra : rnd_op();
      rf = ($urandom_range(0, 9) > 7) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 3) != 0), ra, rb, rf, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), acc);
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
